// File: rtl/sw_alloc_lock_pkg.sv
// -----------------------------------------------------------------------------
// sw_alloc_lock_pkg
// Shared definitions for the per-output switch allocator of the 5-port router:
// router port count, owner-index width and the allocator FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package sw_alloc_lock_pkg;

    // Highest port number; ports are numbered 0..PORT.
    localparam int PORT     = 4;
    // Number of input ports competing for one output.
    localparam int PORT_NP  = PORT + 1;
    // Width of an input-port index; 2**OWNER_IW must cover PORT_NP.
    localparam int OWNER_IW = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/sw_alloc_lock_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Grants the first requester found searching
// upward from ptr and wrapping modulo NP. Shared with the VC allocator.
//
// Ports:
//   req  [NP-1:0]  request vector
//   ptr  [IW-1:0]  highest-priority index (must be < NP)
//   gnt  [NP-1:0]  one-hot grant, zero when no request
//   idx  [IW-1:0]  index of the granted requester, zero when no request
//   any            at least one request present
// -----------------------------------------------------------------------------
module rr_pick
    import sw_alloc_lock_pkg::*;
#(
    parameter int NP = PORT_NP,
    parameter int IW = OWNER_IW
) (
    input  logic [NP-1:0] req,
    input  logic [IW-1:0] ptr,
    output logic [NP-1:0] gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Double-width trick: the lower copy has requests below ptr masked off, the
    // upper copy is intact. A plain fixed-priority scan from bit 0 then sees
    // ptr..NP-1 first and wraps naturally into 0..ptr-1 in the upper copy.
    logic [2*NP-1:0] dreq;

    always_comb begin
        dreq = {req, req};
        for (int j = 0; j < NP; j++) begin
            if (j < int'(ptr)) begin
                dreq[j] = 1'b0;
            end
        end

        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int j = 0; j < 2 * NP; j++) begin
            if (dreq[j] && !any) begin
                any = 1'b1;
                if (j >= NP) begin
                    gnt[j-NP] = 1'b1;
                    idx       = IW'(j - NP);
                end else begin
                    gnt[j] = 1'b1;
                    idx    = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/sw_alloc_lock.sv
// -----------------------------------------------------------------------------
// sw_alloc_lock
// Per-output-port switch allocator. Round-robin arbitration among the head
// flits of NP input ports; the winner keeps the output until its tail flit
// transfers (wormhole switching). One instance per router output.
//
// Ports:
//   clk          router clock, rising edge
//   rst_         asynchronous reset, active-high
//   req  [NP-1:0] input i has a flit for this output
//   tail [NP-1:0] the flit presented by input i is a tail flit
//   stall        downstream cannot accept a flit this cycle
//   grt  [NP-1:0] registered one-hot grant, zero when unowned
//   owner[IW-1:0] index of the granted input, meaningful while busy
//   busy         registered, output locked to a packet
//   xfer         combinational, a flit moves this cycle
// -----------------------------------------------------------------------------
module sw_alloc_lock
    import sw_alloc_lock_pkg::*;
#(
    parameter int NP = PORT_NP,
    parameter int IW = OWNER_IW
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic [NP-1:0] req,
    input  logic [NP-1:0] tail,
    input  logic          stall,
    output logic [NP-1:0] grt,
    output logic [IW-1:0] owner,
    output logic          busy,
    output logic          xfer
);

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q,   ptr_d;
    logic [NP-1:0] grt_q,   grt_d;
    logic [IW-1:0] owner_q, owner_d;
    logic          busy_q,  busy_d;

    logic [NP-1:0] pick_gnt;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          owner_tail;

    // Explicit mod-NP increment; natural IW-bit wrap would land on NP..2**IW-1.
    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] v);
        if (v == IW'(NP - 1)) begin
            return '0;
        end
        return v + IW'(1);
    endfunction

    rr_pick #(
        .NP (NP),
        .IW (IW)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // grt is one-hot on the owner, so masking with it selects req/tail[owner]
    // without indexing by a value that could exceed NP-1.
    assign xfer       = busy_q & (|(req & grt_q)) & ~stall;
    assign owner_tail = |(tail & grt_q);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grt_d   = grt_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grt_d   = pick_gnt;
                    owner_d = pick_idx;
                    busy_d  = 1'b1;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                // Only the owner's tail, and only when it actually moves,
                // releases the lock; the pointer advances past the owner.
                if (xfer && owner_tail) begin
                    grt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = next_ptr(owner_q);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grt_q   <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grt_q   <= grt_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
        end
    end

    assign grt   = grt_q;
    assign owner = owner_q;
    assign busy  = busy_q;

    a_grt_onehot0: assert property (@(posedge clk) disable iff (rst_)
        $onehot0(grt_q));
    a_busy_grt: assert property (@(posedge clk) disable iff (rst_)
        busy_q == (|grt_q));
    a_owner_grt: assert property (@(posedge clk) disable iff (rst_)
        busy_q |-> ((grt_q & (NP'(1) << owner_q)) != '0));
    a_ptr_range: assert property (@(posedge clk) disable iff (rst_)
        int'(ptr_q) < NP);
    a_owner_range: assert property (@(posedge clk) disable iff (rst_)
        int'(owner_q) < NP);

endmodule
